ysyx_23060072_pipe_ctrl: RTL and testbench
==========================================

# ysyx_23060072_pipe_ctrl

Pipeline sequencing controller for the five-stage RV32E core. Generates stall and flush controls for the PC and the IF/ID, ID/EX, EX/LSU and LSU/WB pipeline registers from three sources: load-use hazards, multi-cycle LSU memory transactions, and EX-stage control-flow redirects. It also discards stale in-flight fetches after a redirect and keeps stall/flush performance counters. It sits beside the forwarding unit and covers the hazards that forwarding cannot.

## Interface
- No parameters. Counter width is 32, fixed in the package.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_has_rs1, id_has_rs2  in  1  the instruction in ID reads rs1 / rs2
- id_rs1_addr, id_rs2_addr  in  5  ID source register addresses
- id_store_flag  in  1  the instruction in ID is a store
- id2ex_load_flag  in  1  the instruction in EX is a load
- id2ex_wb_addr  in  5  rd of the instruction in EX
- ex_redirect  in  1  EX resolved a taken branch or jump (new PC is valid this cycle)
- lsu_req_valid  in  1  LSU is issuing or holding a memory request
- lsu_resp_valid  in  1  memory response for the LSU request
- ifu_busy  in  1  IFU has a fetch in flight
- ifu_resp_valid  in  1  IFU fetch response
- pc_stall, if2id_stall, id2ex_stall, ex2lsu_stall  out  1  hold the register
- if2id_flush, id2ex_flush, lsu2wb_flush  out  1  load a bubble (valid=0)
- ifu_resp_drop  out  1  discard the current fetch response
- stall_cnt, flush_cnt  out  32  performance counters

## Operation
- Load-use is combinational: load_use = id2ex_load_flag & (id2ex_wb_addr≠0) & ((id_has_rs1 & rs1==rd) | (id_has_rs2 & rs2==rd & ~id_store_flag)).
  - A store whose rs2 alone matches rd does not stall, because the forwarding unit supplies that value at LSU.
  - When load_use is asserted: pc_stall, if2id_stall and id2ex_flush are 1 for one cycle.
- The LSU FSM has two states, IDLE and LSU_WAIT.
  - IDLE → LSU_WAIT when lsu_req_valid & ~lsu_resp_valid.
  - LSU_WAIT → IDLE on lsu_resp_valid.
  - Freeze condition: (IDLE & lsu_req_valid & ~lsu_resp_valid) | (LSU_WAIT & ~lsu_resp_valid).
  - While frozen: all four stalls are 1, lsu2wb_flush=1, and every other flush is 0.
- Redirect takes effect when ex_redirect is asserted and the pipe is not frozen.
  - if2id_flush=1 and id2ex_flush=1. The PC is not stalled so it loads the target.
  - The load-use stall is suppressed, because the ID instruction is being squashed.
- Priority: freeze > redirect > load-use.
  - A redirect that arrives while frozen stays asserted by EX, which is held, and is acted on in the first unfrozen cycle.
- Drop logic uses a registered bit, drop_pending.
  - Set on an effective redirect when ifu_busy & ~ifu_resp_valid.
  - While drop_pending is set, ifu_resp_drop = ifu_resp_valid.
  - Cleared on the cycle that response arrives.
  - Also asserted combinationally when a redirect and ifu_resp_valid coincide.
- Counters:
  - stall_cnt += 1 on each cycle with a freeze or an effective load-use stall.
  - flush_cnt += 1 on each effective redirect.
  - Both wrap modulo 2^32.

## Timing
- All control outputs are combinational from the inputs and the registered state, with 0-cycle latency.
- State and counters update on the clk rising edge.
- Reset behaviour:
  - Registers: FSM=IDLE, drop_pending=0, counters=0.
  - While rst=1, outputs are forced: all stalls 0, all flushes 1, ifu_resp_drop=1.
  - rst asserted mid-transaction abandons LSU_WAIT and the pending drop, with no carry-over.
- Load-use is exactly one bubble. The next cycle the load is in LSU, and forwarding covers it.
- Simultaneous lsu_req_valid & lsu_resp_valid from IDLE is a single-cycle access: no freeze, no state change.
- Wrap: stall_cnt=0xFFFFFFFF plus one stall cycle gives 0.

## Structure
- Package ysyx_23060072_pkg holds:
  - the FSM state enum (IDLE, LSU_WAIT)
  - CNT_W=32
  - the x0 register-address constant
- Single module, no sub-modules. The counters are inline; a ysyx_23060072_perf_cnt sub-module is optional only if it is reused elsewhere.

## Test plan
- Load x5 in EX, ID `add` reading rs1=x5 → one cycle of pc_stall=if2id_stall=id2ex_flush=1; stall_cnt=1.
- Load x5 in EX, ID store with rs2=x5 and rs1=x6 → no stall. With rs1=x5 → stall. Load rd=x0 → never stalls.
- lsu_req_valid held, resp after 3 cycles → freeze for 3 cycles, lsu2wb_flush=1, FSM returns to IDLE on resp, stall_cnt=3.
- ex_redirect during a 2-cycle freeze → no flush while frozen; if2id_flush=id2ex_flush=1 in the first unfrozen cycle; flush_cnt=1.
- Redirect with ifu_busy=1 and resp arriving 2 cycles later → ifu_resp_drop=1 on exactly that response; drop_pending then cleared.
- Redirect coincident with load_use → redirect flushes only, pc_stall=0, stall_cnt unchanged. rst asserted in LSU_WAIT → next cycle IDLE, counters 0.

Source files
------------

// File: rtl/ysyx_23060072_pkg.sv
// Shared types and constants for the pipeline control slice.
// FSM encoding, counter width and the x0 register address.
package ysyx_23060072_pkg;

  localparam int         CNT_W  = 32;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic {
    IDLE     = 1'b0,
    LSU_WAIT = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/ysyx_23060072_pipe_ctrl.sv
// Stall/flush sequencing for the five-stage RV32E pipe.
// Handles load-use, LSU memory waits, EX redirects and stale fetches.
module ysyx_23060072_pipe_ctrl
  import ysyx_23060072_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_has_rs1,
  input  logic             id_has_rs2,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_store_flag,
  input  logic             id2ex_load_flag,
  input  logic [4:0]       id2ex_wb_addr,
  input  logic             ex_redirect,
  input  logic             lsu_req_valid,
  input  logic             lsu_resp_valid,
  input  logic             ifu_busy,
  input  logic             ifu_resp_valid,
  output logic             pc_stall,
  output logic             if2id_stall,
  output logic             id2ex_stall,
  output logic             ex2lsu_stall,
  output logic             if2id_flush,
  output logic             id2ex_flush,
  output logic             lsu2wb_flush,
  output logic             ifu_resp_drop,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  lsu_state_e       state_q, state_d;
  logic             drop_pending_q, drop_pending_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic freeze;
  logic redir_eff;
  logic lu_eff;

  // Hazard classification: freeze beats redirect beats load-use.
  always_comb begin
    load_use  = 1'b0;
    freeze    = 1'b0;
    redir_eff = 1'b0;
    lu_eff    = 1'b0;
    // A store's rs2 is forwarded at LSU, so it never needs the bubble.
    load_use  = id2ex_load_flag
              & (id2ex_wb_addr != REG_X0)
              & ((id_has_rs1 & (id_rs1_addr == id2ex_wb_addr))
               | (id_has_rs2 & (id_rs2_addr == id2ex_wb_addr)
                  & ~id_store_flag));
    freeze    = ((state_q == IDLE) & lsu_req_valid & ~lsu_resp_valid)
              | ((state_q == LSU_WAIT) & ~lsu_resp_valid);
    redir_eff = ex_redirect & ~freeze;
    lu_eff    = load_use & ~freeze & ~redir_eff;
  end

  // Next-state for LSU FSM, drop tracker and perf counters.
  always_comb begin
    state_d        = state_q;
    drop_pending_d = drop_pending_q;
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    unique case (state_q)
      IDLE:     if (lsu_req_valid & ~lsu_resp_valid) state_d = LSU_WAIT;
      LSU_WAIT: if (lsu_resp_valid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (drop_pending_q & ifu_resp_valid)
      drop_pending_d = 1'b0;
    if (redir_eff & ifu_busy & ~ifu_resp_valid)
      drop_pending_d = 1'b1;
    if (freeze | lu_eff)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (redir_eff)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      drop_pending_q <= 1'b0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      drop_pending_q <= drop_pending_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  // Pipeline control outputs; reset forces bubbles everywhere.
  always_comb begin
    pc_stall      = 1'b0;
    if2id_stall   = 1'b0;
    id2ex_stall   = 1'b0;
    ex2lsu_stall  = 1'b0;
    if2id_flush   = 1'b0;
    id2ex_flush   = 1'b0;
    lsu2wb_flush  = 1'b0;
    ifu_resp_drop = 1'b0;
    if (rst) begin
      if2id_flush   = 1'b1;
      id2ex_flush   = 1'b1;
      lsu2wb_flush  = 1'b1;
      ifu_resp_drop = 1'b1;
    end else begin
      if (freeze) begin
        pc_stall     = 1'b1;
        if2id_stall  = 1'b1;
        id2ex_stall  = 1'b1;
        ex2lsu_stall = 1'b1;
        lsu2wb_flush = 1'b1;
      end else if (redir_eff) begin
        if2id_flush = 1'b1;
        id2ex_flush = 1'b1;
      end else if (lu_eff) begin
        pc_stall    = 1'b1;
        if2id_stall = 1'b1;
        id2ex_flush = 1'b1;
      end
      ifu_resp_drop = ifu_resp_valid & (drop_pending_q | redir_eff);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ysyx_23060072_pipe_ctrl.sv
// Scoreboard bench for ysyx_23060072_pipe_ctrl.
// Driver queues expected outputs; a monitor pops and compares.
module tb_ysyx_23060072_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_has_rs1, id_has_rs2;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        id_store_flag, id2ex_load_flag;
  logic [4:0]  id2ex_wb_addr;
  logic        ex_redirect, lsu_req_valid, lsu_resp_valid;
  logic        ifu_busy, ifu_resp_valid;
  logic        pc_stall, if2id_stall, id2ex_stall, ex2lsu_stall;
  logic        if2id_flush, id2ex_flush, lsu2wb_flush, ifu_resp_drop;
  logic [31:0] stall_cnt, flush_cnt;

  typedef struct {
    string       nm;
    logic [7:0]  o;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ysyx_23060072_pipe_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_has_rs1      (id_has_rs1),
    .id_has_rs2      (id_has_rs2),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_store_flag   (id_store_flag),
    .id2ex_load_flag (id2ex_load_flag),
    .id2ex_wb_addr   (id2ex_wb_addr),
    .ex_redirect     (ex_redirect),
    .lsu_req_valid   (lsu_req_valid),
    .lsu_resp_valid  (lsu_resp_valid),
    .ifu_busy        (ifu_busy),
    .ifu_resp_valid  (ifu_resp_valid),
    .pc_stall        (pc_stall),
    .if2id_stall     (if2id_stall),
    .id2ex_stall     (id2ex_stall),
    .ex2lsu_stall    (ex2lsu_stall),
    .if2id_flush     (if2id_flush),
    .id2ex_flush     (id2ex_flush),
    .lsu2wb_flush    (lsu2wb_flush),
    .ifu_resp_drop   (ifu_resp_drop),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  task automatic clr();
    id_has_rs1      = 1'b0;
    id_has_rs2      = 1'b0;
    id_rs1_addr     = 5'd0;
    id_rs2_addr     = 5'd0;
    id_store_flag   = 1'b0;
    id2ex_load_flag = 1'b0;
    id2ex_wb_addr   = 5'd0;
    ex_redirect     = 1'b0;
    lsu_req_valid   = 1'b0;
    lsu_resp_valid  = 1'b0;
    ifu_busy        = 1'b0;
    ifu_resp_valid  = 1'b0;
  endtask

  // Queue the expectation for the inputs just driven, then advance.
  task automatic apply(input string nm, input logic [7:0] o,
                       input logic [31:0] sc, input logic [31:0] fc);
    exp_t e;
    e.nm = nm;
    e.o  = o;
    e.sc = sc;
    e.fc = fc;
    q.push_back(e);
    @(negedge clk);
    clr();
  endtask

  // Monitor: sample settled outputs shortly before each rising edge.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      #4;
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = {pc_stall, if2id_stall, id2ex_stall, ex2lsu_stall,
               if2id_flush, id2ex_flush, lsu2wb_flush, ifu_resp_drop};
        n_vec++;
        if (act !== e.o || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
          n_bad++;
          $display("FAIL %s: got ctl=%b sc=%0d fc=%0d want ctl=%b sc=%0d fc=%0d",
                   e.nm, act, stall_cnt, flush_cnt, e.o, e.sc, e.fc);
        end
      end
    end
  end

  // Bits: pc,if2id,id2ex,ex2lsu stall | if2id,id2ex,lsu2wb flush | drop
  initial begin
    clr();
    rst = 1'b1;
    @(negedge clk);
    apply("reset", 8'h0F, 0, 0);
    rst = 1'b0;
    apply("idle", 8'h00, 0, 0);

    id2ex_load_flag = 1; id2ex_wb_addr = 5; id_has_rs1 = 1; id_rs1_addr = 5;
    apply("lu_rs1", 8'hC4, 0, 0);
    apply("lu_one_bubble", 8'h00, 1, 0);
    id2ex_load_flag = 1; id2ex_wb_addr = 5; id_store_flag = 1;
    id_has_rs1 = 1; id_rs1_addr = 6; id_has_rs2 = 1; id_rs2_addr = 5;
    apply("st_rs2_only", 8'h00, 1, 0);
    id2ex_load_flag = 1; id2ex_wb_addr = 5; id_store_flag = 1;
    id_has_rs1 = 1; id_rs1_addr = 5; id_has_rs2 = 1; id_rs2_addr = 7;
    apply("st_rs1", 8'hC4, 1, 0);
    id2ex_load_flag = 1; id2ex_wb_addr = 0; id_has_rs1 = 1; id_rs1_addr = 0;
    apply("lu_x0", 8'h00, 2, 0);
    id2ex_load_flag = 1; id2ex_wb_addr = 9; id_has_rs2 = 1; id_rs2_addr = 9;
    apply("lu_rs2", 8'hC4, 2, 0);

    lsu_req_valid = 1;
    apply("frz1", 8'hF2, 3, 0);
    lsu_req_valid = 1;
    apply("frz2", 8'hF2, 4, 0);
    lsu_req_valid = 1;
    apply("frz3", 8'hF2, 5, 0);
    lsu_req_valid = 1; lsu_resp_valid = 1;
    apply("lsu_resp", 8'h00, 6, 0);
    apply("lsu_idle", 8'h00, 6, 0);
    lsu_req_valid = 1; lsu_resp_valid = 1;
    apply("lsu_1cyc", 8'h00, 6, 0);
    apply("lsu_1cyc_after", 8'h00, 6, 0);

    lsu_req_valid = 1; ex_redirect = 1;
    apply("redir_frz1", 8'hF2, 6, 0);
    lsu_req_valid = 1; ex_redirect = 1;
    apply("redir_frz2", 8'hF2, 7, 0);
    lsu_req_valid = 1; lsu_resp_valid = 1; ex_redirect = 1;
    apply("redir_unfrz", 8'h0C, 8, 0);
    apply("redir_done", 8'h00, 8, 1);

    ex_redirect = 1; ifu_busy = 1;
    apply("redir_busy", 8'h0C, 8, 1);
    ifu_busy = 1;
    apply("drop_wait", 8'h00, 8, 2);
    ifu_busy = 1; ifu_resp_valid = 1;
    apply("drop_resp", 8'h01, 8, 2);
    ifu_resp_valid = 1;
    apply("drop_cleared", 8'h00, 8, 2);
    ex_redirect = 1; ifu_resp_valid = 1;
    apply("redir_resp", 8'h0D, 8, 2);

    ex_redirect = 1;
    id2ex_load_flag = 1; id2ex_wb_addr = 5; id_has_rs1 = 1; id_rs1_addr = 5;
    apply("redir_lu", 8'h0C, 8, 3);
    apply("redir_lu_after", 8'h00, 8, 4);

    lsu_req_valid = 1;
    apply("wait_enter", 8'hF2, 8, 4);
    rst = 1; lsu_req_valid = 1;
    apply("rst_in_wait", 8'h0F, 9, 4);
    rst = 0;
    apply("post_rst_idle", 8'h00, 0, 0);
    ex_redirect = 1; ifu_busy = 1;
    apply("redir_busy2", 8'h0C, 0, 0);
    rst = 1;
    apply("rst_drop", 8'h0F, 0, 1);
    rst = 0; ifu_resp_valid = 1;
    apply("post_rst_nodrop", 8'h00, 0, 0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
